// File: rtl/mavg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mavg_pkg
//  Description : Shared sizing helpers and types for the mavg_stream filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mavg_pkg;

  // Largest supported window exponent; sizes the shared fill counter type.
  localparam int c_max_log2_depth = 6;

  // Fill counter wide enough to hold DEPTH for any legal window length.
  typedef logic [c_max_log2_depth:0] fill_t;

  // Number of taps in the window.
  function automatic int depth_of(input int log2_depth);
    return 1 << log2_depth;
  endfunction

  // Running-sum width: a full window of DATA_W samples never overflows it.
  function automatic int acc_width(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  // Half of the divisor, added before the shift for round-half-up.
  function automatic int round_offset(input int log2_depth);
    return 1 << (log2_depth - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mavg_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : mavg_delay_line
//  Description : DEPTH-entry circular sample buffer. Presents the entry that
//                the next write will overwrite (the oldest sample) and can be
//                synchronously zeroed by reset or by the zero strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module mavg_delay_line
  import mavg_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              zero,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] oldest
);

  localparam int c_depth = depth_of(LOG2_DEPTH);

  logic [LOG2_DEPTH-1:0] r_wptr;
  logic [DATA_W-1:0]     r_buf [c_depth];

  // Write the new sample over the oldest slot; the pointer wraps naturally
  // because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset || zero) begin
      r_wptr <= '0;
      for (int i = 0; i < c_depth; i++) begin
        r_buf[i] <= '0;
      end
    end else if (wr_en) begin
      r_buf[r_wptr] <= din;
      r_wptr        <= r_wptr + 1'b1;
    end
  end

  assign oldest = r_buf[r_wptr];

endmodule
`default_nettype wire

// File: rtl/mavg_stream.sv
`default_nettype none
// ============================================================================
//  Module      : mavg_stream
//  Description : Streaming moving-average filter over the last 2**LOG2_DEPTH
//                accepted samples, with registered rounded output, valid
//                handshake, signed/unsigned data and a primed flag.
//                Optional synchronous clear input enabled by defining
//                MAVG_STREAM_CLEAR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mavg_stream
  import mavg_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 2,
  parameter int SIGNED     = 0
) (
  input  logic              clk,
  input  logic              reset,
`ifdef MAVG_STREAM_CLEAR_EN
  input  logic              clear,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x,
  output logic              out_valid,
  output logic [DATA_W-1:0] y,
  output logic              primed
);

  localparam int    c_depth     = depth_of(LOG2_DEPTH);
  localparam int    ACC_W       = acc_width(DATA_W, LOG2_DEPTH);
  localparam logic [ACC_W-1:0] c_round     = ACC_W'(round_offset(LOG2_DEPTH));
  localparam fill_t            c_fill_full = fill_t'(c_depth);

  logic              w_clear;
  logic              w_accept;
  logic [DATA_W-1:0] w_oldest;
  logic [ACC_W-1:0]  w_x_ext;
  logic [ACC_W-1:0]  w_old_ext;
  logic [ACC_W-1:0]  w_acc_n;
  logic [ACC_W-1:0]  w_round;
  logic [DATA_W-1:0] w_y_n;

  logic [ACC_W-1:0]  r_acc;
  fill_t             r_fill;
  logic              r_primed;
  logic [DATA_W-1:0] r_y;
  logic              r_out_valid;

`ifdef MAVG_STREAM_CLEAR_EN
  assign w_clear = clear;
`else
  assign w_clear = 1'b0;
`endif

  // A clear in the same cycle as a sample drops the sample.
  assign w_accept = in_valid && !w_clear;

  mavg_delay_line #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .zero   (w_clear),
    .wr_en  (w_accept),
    .din    (x),
    .oldest (w_oldest)
  );

  // Extend the incoming and outgoing samples to accumulator width and form
  // the rounded average; the truncated result is the same bit slice either
  // way, the arithmetic shift just documents the signed intent.
  if (SIGNED != 0) begin : g_signed
    assign w_x_ext   = {{LOG2_DEPTH{x[DATA_W-1]}}, x};
    assign w_old_ext = {{LOG2_DEPTH{w_oldest[DATA_W-1]}}, w_oldest};
    assign w_y_n     = DATA_W'($signed(w_round) >>> LOG2_DEPTH);
  end else begin : g_unsigned
    assign w_x_ext   = {{LOG2_DEPTH{1'b0}}, x};
    assign w_old_ext = {{LOG2_DEPTH{1'b0}}, w_oldest};
    assign w_y_n     = DATA_W'(w_round >> LOG2_DEPTH);
  end

  assign w_acc_n = r_acc + w_x_ext - w_old_ext;
  assign w_round = w_acc_n + c_round;

  // Running sum, fill tracking and registered output; reset beats clear,
  // clear beats a sample, and y holds whenever no sample is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_fill      <= '0;
      r_primed    <= 1'b0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else if (w_clear) begin
      r_acc       <= '0;
      r_fill      <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_acc       <= w_acc_n;
      r_y         <= w_y_n;
      r_out_valid <= 1'b1;
      if (r_fill != c_fill_full) begin
        r_fill <= r_fill + 1'b1;
      end
      if (r_fill == c_fill_full - 1'b1) begin
        r_primed <= 1'b1;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign primed    = r_primed;

endmodule
`default_nettype wire
